// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================
// fetch_pkg : shared constants and types for the fetch stage
// Rev 1.0
// ============================================================
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_WIDTH       = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================
// fetch_fifo : synchronous FIFO with flush, count and registered head
// Rev 1.0
// ============================================================
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_pop  = pop && (r_count != '0) && !flush;
  assign w_push = push && !flush && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================
// fetch_unit : fetch PC, imem request credits, prefetch FIFO, redirect
// Rev 1.0
// ============================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [31:0]           inst_pc
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int            EW      = $bits(fetch_entry_t);
  localparam logic [CW:0]   c_depth = (CW+1)'(FIFO_DEPTH);

  logic          r_rst_q;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_out_count;
  logic [CW-1:0] w_tag_count;
  logic [31:0]   w_tag_head;
  fetch_entry_t  w_out_head;
  fetch_entry_t  w_out_push_data;
  logic          w_req_hs;
  logic          w_resp_acc;
  logic          w_resp_stale;
  logic          w_resp_live;
  logic          w_resp_push;
  logic          w_consume;

  // Credits: FIFO space must cover live requests, and the tag queue caps total outstanding
  assign imem_req_valid = !r_rst_q
                       && (({1'b0, r_live} + {1'b0, w_out_count}) < c_depth)
                       && (({1'b0, r_live} + {1'b0, r_drop}) < c_depth);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_hs     = imem_req_valid && imem_req_ready;
  assign w_resp_acc   = imem_resp_valid && (w_tag_count != '0);
  assign w_resp_stale = w_resp_acc && (r_drop != '0);
  assign w_resp_live  = w_resp_acc && (r_drop == '0);
  assign w_resp_push  = w_resp_live && !redirect_valid;
  assign w_consume    = inst_valid && inst_ready;

  assign w_out_push_data = '{pc: w_tag_head, instr: imem_resp_data};

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight, including this cycle's request, belongs to the old stream
      r_fetch_pc <= redirect_pc & ~32'h3;
      r_live     <= '0;
      r_drop     <= r_drop + r_live + CW'(w_req_hs) - CW'(w_resp_acc);
    end else begin
      if (w_req_hs) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      r_live <= r_live + CW'(w_req_hs) - CW'(w_resp_live);
      r_drop <= r_drop - CW'(w_resp_stale);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_resp_push),
    .push_data (w_out_push_data),
    .pop       (w_consume),
    .flush     (redirect_valid),
    .count     (w_out_count),
    .head      (w_out_head)
  );

  // Tags are popped by every response, stale or live, so order stays aligned without a flush
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_req_hs),
    .push_data (r_fetch_pc),
    .pop       (w_resp_acc),
    .flush     (1'b0),
    .count     (w_tag_count),
    .head      (w_tag_head)
  );

  assign inst_valid  = (w_out_count != '0);
  assign instruction = w_out_head.instr;
  assign inst_pc     = w_out_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================
// tb_fetch_unit : directed bench with memory model and PC scoreboard
// Rev 1.0
// ============================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc;
  int          cyc, mem_lat, n_vec, n_err, n_req, n_cons;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_stream(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
    exp_req_pc = start;
  endtask

  // One clock: sample handshakes at negedge, score them after the edge, drive next response
  task automatic tick();
    logic        s_req, s_cons, s_redir, s_rst;
    logic [31:0] s_addr, s_pc, s_ins, s_rpc, e;
    mreq_t       m;
    @(negedge clk);
    s_req   = imem_req_valid && imem_req_ready;
    s_addr  = imem_req_addr;
    s_cons  = inst_valid && inst_ready;
    s_pc    = inst_pc;
    s_ins   = instruction;
    s_redir = redirect_valid;
    s_rpc   = redirect_pc;
    s_rst   = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (s_req) begin
      n_req++;
      check("req_addr", s_addr, exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      pend.push_back('{s_addr, cyc + mem_lat - 1});
    end
    if (s_cons) begin
      n_cons++;
      exp_q.push_back(exp_q[$] + 32'd4);
      e = exp_q.pop_front();
      check("inst_pc", s_pc, e);
      check("instruction", s_ins, mem_word(e));
    end
    if (s_redir) new_stream(s_rpc & ~32'h3);
    if (s_rst) begin
      pend.delete();
      new_stream(32'h0000_0000);
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      m = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(m.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_cons(input int n, input string tag);
    int start, b;
    start = n_cons;
    b     = 0;
    while ((n_cons - start) < n && b < 200) begin
      tick();
      b++;
    end
    check(tag, 32'(n_cons - start), 32'(n));
  endtask

  task automatic wait_two_outstanding(input string tag);
    int b;
    b = 0;
    while ((pend.size() + int'(imem_resp_valid)) != 2 && b < 50) begin
      tick();
      b++;
    end
    check(tag, 32'(pend.size() + int'(imem_resp_valid)), 32'd2);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int b, r0;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_lat = 1; cyc = 0; n_vec = 0; n_err = 0; n_req = 0; n_cons = 0;
    new_stream(32'h0000_0000);
    tick();
    tick();

    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_instruction", instruction, 32'h0000_0000);
    check("rst_inst_pc", inst_pc, 32'h0000_0000);

    // Stalled decoder: credits allow exactly two requests, head holds pc 0
    rst = 1'b0;
    tick();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    r0 = n_req;
    tick();
    check("lat_after_req_edge", {31'b0, inst_valid}, 32'd0);
    tick();
    check("lat_after_resp_edge", {31'b0, inst_valid}, 32'd1);
    repeat (8) tick();
    check("stall_req_count", 32'(n_req - r0), 32'd2);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall_head_valid", {31'b0, inst_valid}, 32'd1);
    check("stall_head_pc", inst_pc, 32'h0000_0000);
    check("stall_head_inst", instruction, 32'hA5A5_0000);

    inst_ready = 1'b1;
    run_cons(12, "stream_progress");

    // Latency 3, two outstanding, redirect to an unaligned target
    mem_lat = 3;
    wait_two_outstanding("lat3_outstanding");
    pulse_redirect(32'h0000_0103);
    check("redir_next_addr", imem_req_addr, 32'h0000_0100);
    run_cons(4, "redir_progress");

    // Redirect coinciding with a request handshake and a response
    mem_lat = 1;
    b = 0;
    while (!(imem_req_valid && imem_resp_valid) && b < 50) begin
      tick();
      b++;
    end
    check("same_cycle_setup", {31'b0, imem_req_valid && imem_resp_valid}, 32'd1);
    pulse_redirect(32'h0000_0200);
    run_cons(6, "same_cycle_progress");

    // Address wrap at the top of memory
    mem_lat = 2;
    pulse_redirect(32'hFFFF_FFFC);
    check("wrap_next_addr", imem_req_addr, 32'hFFFF_FFFC);
    run_cons(4, "wrap_progress");

    // One-cycle reset mid-stream with two outstanding
    mem_lat = 3;
    wait_two_outstanding("rst_outstanding");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check("midrst_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("midrst_restart_addr", imem_req_addr, 32'h0000_0000);
    run_cons(5, "midrst_progress");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
